// File: rtl/keypad_pkg.sv
// keypad_pkg: shared keypad types, the fixed 4x4 key map and small helpers.
// Used by the keypad emulator RTL and its command interface.
package keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_BOUNCE,
    ST_HELD,
    ST_RELEASE_BOUNCE
  } kp_state_t;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } key_pos_t;

  // Indexed by hex key code. Layout: "1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D".
  localparam key_pos_t KEY_MAP [0:15] = '{
    '{2'd3, 2'd1},  // 0
    '{2'd0, 2'd0},  // 1
    '{2'd0, 2'd1},  // 2
    '{2'd0, 2'd2},  // 3
    '{2'd1, 2'd0},  // 4
    '{2'd1, 2'd1},  // 5
    '{2'd1, 2'd2},  // 6
    '{2'd2, 2'd0},  // 7
    '{2'd2, 2'd1},  // 8
    '{2'd2, 2'd2},  // 9
    '{2'd0, 2'd3},  // A
    '{2'd1, 2'd3},  // B
    '{2'd2, 2'd3},  // C
    '{2'd3, 2'd3},  // D
    '{2'd3, 2'd0},  // E
    '{2'd3, 2'd2}   // F
  };

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// keypad_emulator_if: scan lines plus press-command handshake of the keypad emulator.
// master = scanner/command source, slave = emulator.
interface keypad_emulator_if
  import keypad_pkg::*;
#(
  parameter int HOLD_W = 16
);
  logic [ROWS-1:0]   rows;
  logic [COLS-1:0]   cols;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_key;
  logic [HOLD_W-1:0] cmd_hold;
  logic              busy;
  logic              done;

  modport master (
    output rows, cmd_valid, cmd_key, cmd_hold,
    input  cols, cmd_ready, busy, done
  );

  modport slave (
    input  rows, cmd_valid, cmd_key, cmd_hold,
    output cols, cmd_ready, busy, done
  );
endinterface

// File: rtl/bounce_lfsr.sv
// bounce_lfsr: 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) producing contact-bounce noise.
// Advances only while en is high; bit_out is the current bit 0.
module bounce_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic int_osc,
  input  logic reset,
  input  logic en,
  output logic bit_out
);
  logic [7:0] r_lfsr;
  logic       w_fb;

  assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge int_osc) begin
    if (reset) begin
      r_lfsr <= SEED;
    end else if (en) begin
      r_lfsr <= {r_lfsr[6:0], w_fb};
    end
  end

  assign bit_out = r_lfsr[0];
endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: answers a 4x4 keypad scanner as if one key were held for a commanded time.
// Contact bounce on press/release is built only when KEYPAD_EMU_BOUNCE_EN is defined.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int         HOLD_W        = 16,
  parameter int         BOUNCE_CYCLES = 64,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic             int_osc,
  input  logic             reset,
  keypad_emulator_if.slave bus
);

  if (BOUNCE_CYCLES < 1 || LFSR_SEED == 8'h00) begin : g_param_check
    $error("keypad_emulator: BOUNCE_CYCLES must be >= 1 and LFSR_SEED nonzero");
  end

`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int CNT_W = max_int(HOLD_W, $clog2(BOUNCE_CYCLES + 1));
  localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'(BOUNCE_CYCLES);
`else
  localparam int CNT_W = HOLD_W;
`endif

  kp_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] w_hold_in;
  logic [1:0]       r_key_row, r_key_col;
  logic [COLS-1:0]  r_cols, w_cols_nxt;
  key_pos_t         w_key_pos;
  logic             w_idle, w_accept, w_contact, w_done;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_accept  = w_idle && bus.cmd_valid;
  assign w_key_pos = KEY_MAP[bus.cmd_key];
  assign w_hold_in = (bus.cmd_hold == '0) ? CNT_W'(1) : CNT_W'(bus.cmd_hold);

`ifdef KEYPAD_EMU_BOUNCE_EN
  logic             w_lfsr_en, w_lfsr_bit;
  logic [CNT_W-1:0] r_hold;

  bounce_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .int_osc (int_osc),
    .reset   (reset),
    .en      (w_lfsr_en),
    .bit_out (w_lfsr_bit)
  );

  always_ff @(posedge int_osc) begin
    if (reset) begin
      r_hold <= '0;
    end else if (w_accept) begin
      r_hold <= w_hold_in;
    end
  end
`endif

  always_ff @(posedge int_osc) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_key_row <= '0;
      r_key_col <= '0;
      r_cols    <= '1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cols  <= w_cols_nxt;
      if (w_accept) begin
        r_key_row <= w_key_pos.row;
        r_key_col <= w_key_pos.col;
      end
    end
  end

  // The final state of a press lingers one extra cycle with count 0: contact released, done raised.
  // NOTE: every always_comb output is defaulted first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_contact   = 1'b0;
    w_done      = 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
    w_lfsr_en   = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
          w_state_nxt = ST_PRESS_BOUNCE;
          w_cnt_nxt   = BOUNCE_LOAD;
`else
          w_state_nxt = ST_HELD;
          w_cnt_nxt   = w_hold_in;
`endif
        end
      end
`ifdef KEYPAD_EMU_BOUNCE_EN
      ST_PRESS_BOUNCE: begin
        w_contact = w_lfsr_bit;
        w_lfsr_en = 1'b1;
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = ST_HELD;
          w_cnt_nxt   = r_hold;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
`endif
      ST_HELD: begin
        if (r_cnt == '0) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_contact = 1'b1;
          w_cnt_nxt = r_cnt - CNT_W'(1);
`ifdef KEYPAD_EMU_BOUNCE_EN
          if (r_cnt == CNT_W'(1)) begin
            w_state_nxt = ST_RELEASE_BOUNCE;
            w_cnt_nxt   = BOUNCE_LOAD;
          end
`endif
        end
      end
`ifdef KEYPAD_EMU_BOUNCE_EN
      ST_RELEASE_BOUNCE: begin
        if (r_cnt == '0) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_contact = w_lfsr_bit;
          w_lfsr_en = 1'b1;
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // A column answers only while its key makes contact and the key's own row is being scanned.
  always_comb begin
    w_cols_nxt = '1;
    if (w_contact && !bus.rows[r_key_row]) begin
      w_cols_nxt[r_key_col] = 1'b0;
    end
  end

  assign bus.cols      = r_cols;
  assign bus.cmd_ready = w_idle;
  assign bus.busy      = !w_idle;
  assign bus.done      = w_done;

endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: scoreboard bench for keypad_emulator (both bounce builds).
// Expected column values are queued when rows/contact are driven and popped one cycle later.
module tb_keypad_emulator;

  localparam int         HOLD_W = 16;
  localparam int         BOUNCE = 8;
  localparam logic [7:0] SEED   = 8'hA5;
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int B_EFF = BOUNCE;
`else
  localparam int B_EFF = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  keypad_emulator_if #(.HOLD_W(HOLD_W)) bus ();

  keypad_emulator #(
    .HOLD_W        (HOLD_W),
    .BOUNCE_CYCLES (BOUNCE),
    .LFSR_SEED     (SEED)
  ) dut (
    .int_osc (clk),
    .reset   (rst),
    .bus     (bus)
  );

  int         n_pass  = 0;
  int         n_total = 0;
  logic [7:0] m_lfsr;
  logic [3:0] exp_q [$];

  // Physical layout, row-major: row0 "1 2 3 A" ... row3 "E 0 F D".
  logic [3:0] layout [0:15] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'hE, 4'h0, 4'hF, 4'hD};

  function automatic logic [3:0] exp_cols(input logic [3:0] key, input logic contact,
                                          input logic [3:0] rows);
    logic [3:0] c;
    c = 4'hF;
    for (int i = 0; i < 16; i++) begin
      if (layout[i] == key && contact && rows[i / 4] == 1'b0) c[i % 4] = 1'b0;
    end
    return c;
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // mode 0: walk one low row per cycle, 1: fixed value, 2: alternate all-low / all-high
  function automatic logic [3:0] rows_pat(input int mode, input logic [3:0] fixed, input int k);
    logic [3:0] one_hot;
    one_hot = 4'b0001 << (k % 4);
    case (mode)
      0:       return ~one_hot;
      1:       return fixed;
      default: return (k % 2 == 1) ? 4'hF : 4'h0;
    endcase
  endfunction

  task automatic run_cmd(input string name, input logic [3:0] key, input int hold,
                         input int mode, input logic [3:0] fixed, input int inject_k,
                         input bit chain, input logic [3:0] next_key, input int next_hold);
    int         h, t, last;
    logic       c;
    logic [3:0] rw, exp_c;
    logic [2:0] st_exp, st_got;
    h    = (hold == 0) ? 1 : hold;
    t    = 2 * B_EFF + h + 1;
    last = chain ? t : t + 1;
    @(negedge clk);
    n_total++;
    if ({bus.busy, bus.done, bus.cmd_ready, bus.cols} !== {3'b001, 4'hF})
      $display("FAIL %s idle_before_cmd busy/done/ready/cols=%b/%b/%b/%b required 0/0/1/1111",
               name, bus.busy, bus.done, bus.cmd_ready, bus.cols);
    else n_pass++;
    exp_q.delete();
    bus.cmd_valid = 1'b1;
    bus.cmd_key   = key;
    bus.cmd_hold  = HOLD_W'(hold);
    rw = rows_pat(mode, fixed, 0);
    bus.rows = rw;
    exp_q.push_back(4'hF);
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      exp_c = exp_q.pop_front();
      n_total++;
      if (bus.cols !== exp_c)
        $display("FAIL %s cols k=%0d got %b required %b", name, k, bus.cols, exp_c);
      else n_pass++;
      st_exp = {k <= t, k == t, k > t};
      st_got = {bus.busy, bus.done, bus.cmd_ready};
      n_total++;
      if (st_got !== st_exp)
        $display("FAIL %s busy/done/ready k=%0d got %b required %b", name, k, st_got, st_exp);
      else n_pass++;
      if (k == 1) bus.cmd_valid = 1'b0;
      if (inject_k != 0 && k == inject_k) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_key   = ~key;
      end
      if (inject_k != 0 && k == inject_k + 1) bus.cmd_valid = 1'b0;
      if (k <= B_EFF || (k > B_EFF + h && k <= 2 * B_EFF + h)) begin
        c      = m_lfsr[0];
        m_lfsr = lfsr_step(m_lfsr);
      end else begin
        c = (k <= B_EFF + h);
      end
      rw = rows_pat(mode, fixed, k);
      bus.rows = rw;
      exp_q.push_back(exp_cols(key, c, rw));
      if (chain && k == t) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_key   = next_key;
        bus.cmd_hold  = HOLD_W'(next_hold);
      end
    end
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_key   = 4'h0;
    bus.cmd_hold  = '0;
    bus.rows      = 4'hF;
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    m_lfsr = SEED;
    n_total++;
    if ({bus.cols, bus.busy, bus.done, bus.cmd_ready} !== {4'hF, 3'b001})
      $display("FAIL reset_state cols/busy/done/ready=%b/%b/%b/%b required 1111/0/0/1",
               bus.cols, bus.busy, bus.done, bus.cmd_ready);
    else n_pass++;
  endtask

  task automatic test_walk_key5();
    run_cmd("walk_key5", 4'h5, 10, 0, 4'hF, 0, 1'b0, 4'h0, 0);
  endtask

  task automatic test_hold_zero();
    run_cmd("hold_zero_keyD", 4'hD, 0, 1, 4'b0111, 0, 1'b0, 4'h0, 0);
  endtask

  task automatic test_bounce_key1();
    run_cmd("bounce_key1", 4'h1, 5, 1, 4'b1110, 0, 1'b0, 4'h0, 0);
  endtask

  task automatic test_back_to_back();
    run_cmd("ignore_then_chain", 4'h9, 6, 1, 4'b1011, B_EFF + 2, 1'b1, 4'hB, 3);
    run_cmd("chained_keyB", 4'hB, 3, 0, 4'hF, 0, 1'b0, 4'h0, 0);
  endtask

  task automatic test_reset_mid_hold();
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_key   = 4'h0;
    bus.cmd_hold  = HOLD_W'(20);
    bus.rows      = 4'b0111;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (B_EFF + 2) @(negedge clk);
    n_total++;
    if (bus.cols !== 4'b1101)
      $display("FAIL mid_hold_pressed cols got %b required 1101", bus.cols);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    m_lfsr = SEED;
    n_total++;
    if ({bus.cols, bus.busy, bus.done, bus.cmd_ready} !== {4'hF, 3'b001})
      $display("FAIL mid_hold_reset cols/busy/done/ready=%b/%b/%b/%b required 1111/0/0/1",
               bus.cols, bus.busy, bus.done, bus.cmd_ready);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++;
      if ({bus.cols, bus.busy, bus.done} !== {4'hF, 2'b00})
        $display("FAIL post_reset_quiet i=%0d cols/busy/done=%b/%b/%b required 1111/0/0",
                 i, bus.cols, bus.busy, bus.done);
      else n_pass++;
    end
  endtask

  task automatic test_row_alternate();
    run_cmd("rows_all_low_keyC", 4'hC, 4, 2, 4'hF, 0, 1'b0, 4'h0, 0);
  endtask

  initial begin
    test_reset();
    test_walk_key5();
    test_hold_zero();
    test_bounce_key1();
    test_back_to_back();
    test_reset_mid_hold();
    test_row_alternate();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
Synthesizable 4x4 matrix-keypad responder. It is the far end of the keypad scan interface: it watches the row lines driven by the keypad scanner and drives the column lines exactly as a physical keypad with one pressed key would. It presses a commanded key for a programmed hold time, with optional contact bounce on press and release. Used for FPGA loopback bring-up of the scanner and 2-digit display path, and as a bench stimulus model.

Parameters:
HOLD_W, 16, width of hold-time command in clock cycles
BOUNCE_CYCLES, 64, length of each bounce window (press and release), >=1
LFSR_SEED, 8'hA5, reset value of bounce LFSR, must be nonzero

Ports:
int_osc  input  1  system clock (24 MHz)
reset  input  1  synchronous, active-high reset
rows  input  4  row lines from scanner; active-low, a low row is being scanned
cols  output  4  column lines to scanner; active-low, high = no contact
cmd_valid  input  1  press command valid
cmd_ready  output  1  emulator can accept a command
cmd_key  input  4  hex key code to press
cmd_hold  input  HOLD_W  stable-hold duration in cycles (0 treated as 1)
busy  output  1  high from command accept until release complete
done  output  1  one-cycle pulse when release finishes

Behaviour:
- Key map, fixed (row 0..3, col 0..3): row0 "1 2 3 A", row1 "4 5 6 B", row2 "7 8 9 C", row3 "E 0 F D". cmd_key is decoded to key_row/key_col at accept and latched.
- contact is an internal bit. Registered output: cols[c] <= ~(contact && c==key_col && rows[key_row]==0). One-cycle latency from rows/contact to cols. Multiple low rows are legal: the key responds if its own row is low.
- FSM states: IDLE, PRESS_BOUNCE, HELD, RELEASE_BOUNCE.
- IDLE: contact=0, cmd_ready=1, busy=0. A command is accepted on cmd_valid&&cmd_ready. It latches the key and hold, loads the counter, and moves to PRESS_BOUNCE.
- PRESS_BOUNCE: contact = LFSR bit0, LFSR advances every cycle. Lasts BOUNCE_CYCLES cycles, then goes to HELD.
- HELD: contact=1 for max(cmd_hold,1) cycles, then goes to RELEASE_BOUNCE.
- RELEASE_BOUNCE: contact = LFSR bit0 for BOUNCE_CYCLES cycles. Then contact=0, done pulses for one cycle, and the FSM goes to IDLE.
- cmd_ready=0 and busy=1 in all non-IDLE states. cmd_valid while busy is ignored; there is no queuing.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifts only in bounce states.
- Down-counter width = max(HOLD_W, clog2(BOUNCE_CYCLES+1)). It never wraps. Terminal count is 1 -> transition.
- Reset (any state, including mid-press): state=IDLE, cols=4'hF, cmd_ready=1 (combinational from state), busy=0, done=0, contact=0, LFSR=LFSR_SEED, counter=0, latched key=0.
- cmd_valid in the same cycle that done pulses: not accepted (state is not yet IDLE). It is accepted the next cycle if still valid.

Optional Feature:
KEYPAD_EMU_BOUNCE_EN. When defined, bounce windows behave as above. When undefined, PRESS_BOUNCE and RELEASE_BOUNCE are skipped: accept goes directly to HELD, HELD expiry goes directly to IDLE with the done pulse, the LFSR is not instantiated, and BOUNCE_CYCLES is unused. Total busy time is then hold+1 cycles.

Decomposition:
- Package keypad_pkg:
  - typedef for the FSM state enum
  - typedef struct {row[1:0], col[1:0]} key_pos_t
  - constant 16-entry key-map array (key code -> key_pos_t)
  - ROWS=4 and COLS=4 constants
- The scanner reuses the same map inverted.
- One natural sub-module: bounce_lfsr (int_osc, reset, en, bit_out).

Test Plan:
1. Bounce off, reset, cmd_key=4'h5, hold=10; scanner model walks rows 1110,1101,1011,0111 per cycle -> cols=4'b1101 exactly one cycle after rows=1101 for 10 HELD cycles, else 4'hF; done at busy-end; busy high 11 cycles.
2. cmd_key=4'hD, hold=0 -> treated as 1; contact 1 cycle; with rows=4'b0111, cols=4'b0111 once, then done.
3. Bounce on, BOUNCE_CYCLES=8, seed A5, key 4'h1, rows held 4'b1110 -> cols[0] follows LFSR bit0 sequence for 8 cycles, low 5 cycles (hold=5), LFSR for 8, then 4'hF; busy=22 cycles.
4. Second cmd_valid during HELD -> ignored, cmd_ready=0; held cmd_valid on done cycle accepted exactly the next cycle.
5. reset asserted mid-HELD with key 4'h0 pressed -> next cycle cols=4'hF, busy=0, cmd_ready=1, no done pulse.
6. rows=4'b0000 with key 4'hC -> cols=4'b0111; rows=4'hF -> cols=4'hF regardless of contact.
